// File: rtl/cache_control_if.sv
// Handshake and datapath bundle for the L1 cache controller.
// The master side is the controller. The slave side is the CPU, physical memory and the cache datapath.
interface cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;

    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;
    logic pmem_addr_sel;

    logic ishit_w1;
    logic ishit_w2;
    logic isdirty_w1;
    logic isdirty_w2;
    logic isvalid_w1;
    logic isvalid_w2;
    logic lru_out;

    logic load_tag_w1;
    logic load_tag_w2;
    logic load_valid_w1;
    logic load_valid_w2;
    logic load_dirty_w1;
    logic load_dirty_w2;
    logic dirty_in;
    logic load_datastore_w1;
    logic load_datastore_w2;
    logic datastore_in_mux_sel;
    logic load_lru;
    logic lru_in;

    modport master (
        input  mem_read, mem_write, pmem_resp,
               ishit_w1, ishit_w2, isdirty_w1, isdirty_w2,
               isvalid_w1, isvalid_w2, lru_out,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel,
               load_tag_w1, load_tag_w2, load_valid_w1, load_valid_w2,
               load_dirty_w1, load_dirty_w2, dirty_in,
               load_datastore_w1, load_datastore_w2, datastore_in_mux_sel,
               load_lru, lru_in
    );

    modport slave (
        output mem_read, mem_write, pmem_resp,
               ishit_w1, ishit_w2, isdirty_w1, isdirty_w2,
               isvalid_w1, isvalid_w2, lru_out,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel,
               load_tag_w1, load_tag_w2, load_valid_w1, load_valid_w2,
               load_dirty_w1, load_dirty_w2, dirty_in,
               load_datastore_w1, load_datastore_w2, datastore_in_mux_sel,
               load_lru, lru_in
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache.
// It sequences hits, dirty-victim writeback and line allocation, and keeps saturating hit/miss counters.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_control_if.master      bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        HIT_CHECK,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state;
    state_t next_state;

    logic missed;
    logic set_missed;
    logic req;
    logic hit;
    logic hit_way2;
    logic victim_dirty;

    logic resp;
    logic ld_tag_w1, ld_tag_w2;
    logic ld_valid_w1, ld_valid_w2;
    logic ld_dirty_w1, ld_dirty_w2;
    logic ld_data_w1, ld_data_w2;
    logic ld_lru;

    assign req          = bus.mem_read | bus.mem_write;
    assign hit          = bus.ishit_w1 | bus.ishit_w2;
    // A double hit is illegal; way 1 takes priority.
    assign hit_way2     = bus.ishit_w2 & ~bus.ishit_w1;
    assign victim_dirty = bus.lru_out ? (bus.isvalid_w2 & bus.isdirty_w2)
                                      : (bus.isvalid_w1 & bus.isdirty_w1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HIT_CHECK;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state               = state;
        set_missed               = 1'b0;
        resp                     = 1'b0;
        bus.pmem_read            = 1'b0;
        bus.pmem_write           = 1'b0;
        bus.pmem_addr_sel        = 1'b0;
        bus.dirty_in             = 1'b0;
        bus.datastore_in_mux_sel = 1'b0;
        bus.lru_in               = 1'b0;
        ld_tag_w1                = 1'b0;
        ld_tag_w2                = 1'b0;
        ld_valid_w1              = 1'b0;
        ld_valid_w2              = 1'b0;
        ld_dirty_w1              = 1'b0;
        ld_dirty_w2              = 1'b0;
        ld_data_w1               = 1'b0;
        ld_data_w2               = 1'b0;
        ld_lru                   = 1'b0;

        case (state)
            HIT_CHECK: begin
                if (req && hit) begin
                    resp       = 1'b1;
                    ld_lru     = 1'b1;
                    bus.lru_in = ~hit_way2;
                    if (bus.mem_write) begin
                        bus.dirty_in = 1'b1;
                        if (hit_way2) begin
                            ld_data_w2  = 1'b1;
                            ld_dirty_w2 = 1'b1;
                        end else begin
                            ld_data_w1  = 1'b1;
                            ld_dirty_w1 = 1'b1;
                        end
                    end
                end else if (req) begin
                    set_missed = 1'b1;
                    next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                if (bus.pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    // The LRU array is left alone here; the retried access updates it as a hit.
                    bus.datastore_in_mux_sel = 1'b1;
                    if (bus.lru_out) begin
                        ld_data_w2  = 1'b1;
                        ld_tag_w2   = 1'b1;
                        ld_valid_w2 = 1'b1;
                        ld_dirty_w2 = 1'b1;
                    end else begin
                        ld_data_w1  = 1'b1;
                        ld_tag_w1   = 1'b1;
                        ld_valid_w1 = 1'b1;
                        ld_dirty_w1 = 1'b1;
                    end
                    next_state = HIT_CHECK;
                end
            end

            default: begin
                next_state = HIT_CHECK;
            end
        endcase
    end

    // Reset suppresses every array write so no line is corrupted in the reset cycle.
    assign bus.mem_resp          = resp;
    assign bus.load_tag_w1       = ld_tag_w1   & ~rst;
    assign bus.load_tag_w2       = ld_tag_w2   & ~rst;
    assign bus.load_valid_w1     = ld_valid_w1 & ~rst;
    assign bus.load_valid_w2     = ld_valid_w2 & ~rst;
    assign bus.load_dirty_w1     = ld_dirty_w1 & ~rst;
    assign bus.load_dirty_w2     = ld_dirty_w2 & ~rst;
    assign bus.load_datastore_w1 = ld_data_w1  & ~rst;
    assign bus.load_datastore_w2 = ld_data_w2  & ~rst;
    assign bus.load_lru          = ld_lru      & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            missed     <= 1'b0;
        end else if (resp) begin
            if (missed) begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end else if (hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            missed <= 1'b0;
        end else if (set_missed) begin
            missed <= 1'b1;
        end
    end

endmodule
